// File: rtl/tdec_bi.sv
// -----------------------------------------------------------------------------
// tdec_bi : temporal/stochastic bitstream decoder (bipolar by default)
//
// Counts the ones in one bitstream window (the run of cycles where iStop is
// low). On the edge that sees iStop high again, the count is converted to a
// signed bipolar value 2*ones - len. The result is presented on a valid/ready
// port for the downstream adder tree / MAC accumulator.
//
// Handshake: a result transfers on a rising clk edge where oValid=1 and
// iReady=1. oSum/oLen hold while oValid=1 and iReady=0. A new window result
// always loads, even if the previous one was not consumed (that sets oOvr).
//
// Optional build macro:
//   TDEC_UNIPOLAR_EN  when defined, oSum carries the plain ones count
//                     {1'b0, ones} instead of the bipolar value.
//
// Parameters:
//   CNTWD   width of the ones and length counters (max window 2^CNTWD-1)
//
// Ports:
//   clk     clock
//   rst_n   asynchronous active-low reset
//   iBit    bitstream data, sampled only while iStop=0
//   iStop   window delimiter: 0 = window active, 1 = idle / window end
//   iClr    synchronous clear of the sticky flags oOvr and oSat
//   oSum    signed (two's complement) result, CNTWD+1 bits
//   oLen    window length belonging to the result on oSum
//   oValid  result available
//   iReady  downstream accepts the result
//   oBusy   window accumulation in progress
//   oOvr    sticky: an unconsumed result was overwritten
//   oSat    sticky: a counter saturated in some window
//   oState  debug view of the accumulation FSM (0 = IDLE, 1 = ACC)
// -----------------------------------------------------------------------------
module tdec_bi #(
  parameter int CNTWD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iBit,
  input  logic             iStop,
  input  logic             iClr,
  output logic [CNTWD:0]   oSum,
  output logic [CNTWD-1:0] oLen,
  output logic             oValid,
  input  logic             iReady,
  output logic             oBusy,
  output logic             oOvr,
  output logic             oSat,
  output logic             oState
);

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  localparam logic [CNTWD-1:0] LEN_MAX = '1;

  state_e           state_q, state_d;
  logic [CNTWD-1:0] ones_q, ones_d;
  logic [CNTWD-1:0] len_q, len_d;
  logic [CNTWD:0]   sum_q, sum_d;
  logic [CNTWD-1:0] olen_q, olen_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;
  logic             sat_q, sat_d;

  logic             load;
  logic             sat_set;
  logic [CNTWD:0]   res_sum;

  // Result of the window currently held in the counters. In CNTWD+1 bits
  // 2*ones can wrap, but the difference always lies in -len..+len, which
  // fits, so modular arithmetic gives the exact signed value.
`ifdef TDEC_UNIPOLAR_EN
  assign res_sum = {1'b0, ones_q};
`else
  assign res_sum = {ones_q, 1'b0} - {1'b0, len_q};
`endif

  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    len_d   = len_q;
    busy_d  = busy_q;
    load    = 1'b0;
    sat_set = 1'b0;

    case (state_q)
      IDLE: begin
        // Counters restart only here, so they still hold the last window
        // while idle.
        if (!iStop) begin
          state_d = ACC;
          ones_d  = {{(CNTWD-1){1'b0}}, iBit};
          len_d   = {{(CNTWD-1){1'b0}}, 1'b1};
          busy_d  = 1'b1;
        end
      end
      ACC: begin
        if (!iStop) begin
          if (len_q == LEN_MAX) begin
            // Length is pinned at its maximum: both counters freeze for the
            // rest of the window and the event is recorded.
            sat_set = 1'b1;
          end else begin
            ones_d = ones_q + {{(CNTWD-1){1'b0}}, iBit};
            len_d  = len_q + {{(CNTWD-1){1'b0}}, 1'b1};
          end
        end else begin
          // Window end; the iBit of this cycle is not part of the window.
          state_d = IDLE;
          busy_d  = 1'b0;
          load    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    sum_d  = load ? res_sum : sum_q;
    olen_d = load ? len_q   : olen_q;

    if (load) begin
      valid_d = 1'b1;
    end else if (valid_q && iReady) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    // Set events take priority over a simultaneous clear. A load that
    // coincides with a transfer (iReady=1) is not an overrun.
    ovr_d = (ovr_q & ~iClr) | (load & valid_q & ~iReady);
    sat_d = (sat_q & ~iClr) | sat_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ones_q  <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      olen_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      olen_q  <= olen_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      sat_q   <= sat_d;
    end
  end

  assign oSum   = sum_q;
  assign oLen   = olen_q;
  assign oValid = valid_q;
  assign oBusy  = busy_q;
  assign oOvr   = ovr_q;
  assign oSat   = sat_q;
  assign oState = state_q;

endmodule
